inst_fetch: RTL

- Instruction fetch unit: the producer side of the instruction word consumed by the control decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {pc, inst} to decode with a valid/ready handshake.
- Takes redirects (jal/jalr/taken branch, decoder PCsel with target) and flushes stale instructions.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/inst_fetch.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int unsigned PC_STEP  = 4;

    function automatic logic [63:0] pc_align(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order {pc, inst} buffer between instruction memory and decode.
// Flush wins over a same-cycle push.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, credit-limited imem requests, response FIFO, redirect.
// Define FETCH_PERF_EN to add the perf_fetched/perf_bubbles counters.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
`ifdef FETCH_PERF_EN
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_bubbles,
`endif
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [N-1:0] imem_rsp_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [N-1:0] inst,
    output logic [N-1:0] inst_pc,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc
);

    localparam int            CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_e   state_q, state_d;
    logic [N-1:0]   fetch_pc_q, fetch_pc_d;
    logic [N-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]  out_q, out_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic [CW-1:0]  fifo_cnt;
    logic [CW:0]    used;
    logic           fifo_full, fifo_empty;
    logic           push, pop;
    logic           req_fire, rsp_live;
    logic [N-1:0]   target;
    logic [2*N-1:0] head;

    assign target   = N'(pc_align(64'(redirect_pc)));
    assign used     = {1'b0, out_q} + {1'b0, fifo_cnt};
    // Credit uses registered occupancy, so a same-cycle pop frees nothing.
    assign imem_req_valid = (state_q != IDLE) && !redirect && (used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_live = imem_rsp_valid && (out_q != '0);

    assign inst_valid = !fifo_empty;
    assign pop        = inst_valid && inst_ready;
    assign inst       = fifo_empty ? N'(NOP_INST) : head[N-1:0];
    assign inst_pc    = fifo_empty ? '0 : head[2*N-1:N];

    always_comb begin
        out_d      = out_q + CW'(req_fire) - CW'(rsp_live);
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        push       = 1'b0;
        if (req_fire) fetch_pc_d = fetch_pc_q + N'(PC_STEP);
        if (rsp_live) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else begin
                push     = !redirect;
                rsp_pc_d = rsp_pc_q + N'(PC_STEP);
            end
        end
        // Everything still in flight at a redirect is stale.
        if (redirect) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            drop_d     = out_d;
        end
        state_d = (drop_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .W     (2*N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i   (pop),
        .flush_i (redirect),
        .rdata_o (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always @(posedge clk) begin
        if (rst && imem_rsp_valid) begin
            assert (out_q != '0);
            assert (!fifo_full);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, bubbles_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (pop && fetched_q != '1)
                fetched_q <= fetched_q + 32'd1;
            if (inst_ready && fifo_empty && bubbles_q != '1)
                bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule
